// File: rtl/ed25519_smul_arbiter.sv
// rtl/ed25519_smul_arbiter.sv - two-port round-robin arbiter/sequencer for the shared Ed25519 scalar-mult engine
module ed25519_smul_arbiter #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000,
    parameter int          CNT_W          = 20
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          rq0_valid,
    output logic          rq0_ready,
    input  logic [255:0]  rq0_scalar,
    input  logic [1019:0] rq0_point,
    output logic          rs0_valid,
    input  logic          rs0_ready,
    output logic [1019:0] rs0_point,
    output logic          rs0_err,

    input  logic          rq1_valid,
    output logic          rq1_ready,
    input  logic [255:0]  rq1_scalar,
    input  logic [1019:0] rq1_point,
    output logic          rs1_valid,
    input  logic          rs1_ready,
    output logic [1019:0] rs1_point,
    output logic          rs1_err,

    output logic          mul_start,
    output logic [255:0]  mul_scalar,
    output logic [254:0]  mul_base_x,
    output logic [254:0]  mul_base_y,
    output logic [254:0]  mul_base_z,
    output logic [254:0]  mul_base_t,
    input  logic [254:0]  mul_res_x,
    input  logic [254:0]  mul_res_y,
    input  logic [254:0]  mul_res_z,
    input  logic [254:0]  mul_res_t,
    input  logic          mul_done,
    input  logic          mul_busy,

    output logic [7:0]    timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            grant;
    logic            last_grant;
    logic            pick;
    logic            req_any;
    logic            rs_take;
    logic            wd_expired;

    logic [255:0]    op_scalar;
    logic [1019:0]   op_point;
    logic [1019:0]   res_point;
    logic            res_err;
    logic [CNT_W-1:0] wd;

    // Winner when both ports ask is the one not served last; otherwise the lone requester.
    assign pick       = (rq0_valid && rq1_valid) ? ~last_grant : rq1_valid;
    assign req_any    = rq0_valid || rq1_valid;
    assign rs_take    = (state == RESP) && (grant ? rs1_ready : rs0_ready);
    // The counter holds the number of WAIT cycles already spent, so the run is
    // abandoned on the cycle that would make it TIMEOUT_CYCLES.
    assign wd_expired = (wd == CNT_W'(TIMEOUT_CYCLES - 32'd1));

    // Operands feed the engine directly; they only change in ACCEPT, so they
    // stay frozen for the whole ladder run.
    assign mul_scalar = op_scalar;
    assign mul_base_x = op_point[254:0];
    assign mul_base_y = op_point[509:255];
    assign mul_base_z = op_point[764:510];
    assign mul_base_t = op_point[1019:765];

    assign rs0_point  = res_point;
    assign rs1_point  = res_point;
    assign rs0_err    = rs0_valid & res_err;
    assign rs1_err    = rs1_valid & res_err;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        rq0_ready = 1'b0;
        rq1_ready = 1'b0;
        rs0_valid = 1'b0;
        rs1_valid = 1'b0;
        mul_start = 1'b0;
        case (state)
            IDLE: begin
                if (!mul_busy && req_any) begin
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                rq0_ready = ~grant;
                rq1_ready = grant;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!mul_busy) begin
                    mul_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mul_done || wd_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rs0_valid = ~grant;
                rs1_valid = grant;
                if (rs_take) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping: pick a winner leaving IDLE, remember it once its response is consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (state == IDLE && !mul_busy && req_any) begin
                grant <= pick;
            end
            if (rs_take) begin
                last_grant <= grant;
            end
        end
    end

    // Operand capture from the granted requester during the accept cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_scalar <= '0;
            op_point  <= '0;
        end else if (state == ACCEPT) begin
            op_scalar <= grant ? rq1_scalar : rq0_scalar;
            op_point  <= grant ? rq1_point  : rq0_point;
        end
    end

    // Watchdog: cleared on the start pulse, counts every WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd <= '0;
        end else if (state == ISSUE && !mul_busy) begin
            wd <= '0;
        end else if (state == WAIT) begin
            wd <= wd + 1'b1;
        end
    end

    // Result capture; a completion in the same cycle as expiry is honoured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_point   <= '0;
            res_err     <= 1'b0;
            timeout_cnt <= 8'd0;
        end else if (state == WAIT) begin
            if (mul_done) begin
                res_point <= {mul_res_t, mul_res_z, mul_res_y, mul_res_x};
                res_err   <= 1'b0;
            end else if (wd_expired) begin
                res_point <= '0;
                res_err   <= 1'b1;
                if (timeout_cnt != 8'hFF) begin
                    timeout_cnt <= timeout_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ed25519_smul_arbiter.sv
// tb/tb_ed25519_smul_arbiter.sv - self-checking bench for ed25519_smul_arbiter with an engine stub
module tb_ed25519_smul_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rq_valid  [2];
    logic          rq_ready  [2];
    logic [255:0]  rq_scalar [2];
    logic [1019:0] rq_point  [2];
    logic          rs_valid  [2];
    logic          rs_ready  [2];
    logic [1019:0] rs_point  [2];
    logic          rs_err    [2];

    logic          mul_start;
    logic [255:0]  mul_scalar;
    logic [254:0]  mul_base_x, mul_base_y, mul_base_z, mul_base_t;
    logic [254:0]  mul_res_x = '0, mul_res_y = '0, mul_res_z = '0, mul_res_t = '0;
    logic          mul_done = 1'b0;
    logic          mul_busy;
    logic [7:0]    timeout_cnt;

    ed25519_smul_arbiter #(.TIMEOUT_CYCLES(32'd100), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq_valid[0]), .rq0_ready(rq_ready[0]), .rq0_scalar(rq_scalar[0]), .rq0_point(rq_point[0]),
        .rs0_valid(rs_valid[0]), .rs0_ready(rs_ready[0]), .rs0_point(rs_point[0]), .rs0_err(rs_err[0]),
        .rq1_valid(rq_valid[1]), .rq1_ready(rq_ready[1]), .rq1_scalar(rq_scalar[1]), .rq1_point(rq_point[1]),
        .rs1_valid(rs_valid[1]), .rs1_ready(rs_ready[1]), .rs1_point(rs_point[1]), .rs1_err(rs_err[1]),
        .mul_start(mul_start), .mul_scalar(mul_scalar),
        .mul_base_x(mul_base_x), .mul_base_y(mul_base_y), .mul_base_z(mul_base_z), .mul_base_t(mul_base_t),
        .mul_res_x(mul_res_x), .mul_res_y(mul_res_y), .mul_res_z(mul_res_z), .mul_res_t(mul_res_t),
        .mul_done(mul_done), .mul_busy(mul_busy), .timeout_cnt(timeout_cnt)
    );

    // Engine contract used by the stub and by the expected-value model.
    function automatic logic [1019:0] eng_f(input logic [255:0] s, input logic [1019:0] p);
        logic [254:0] x, y, z, t;
        x = p[254:0] ^ s[254:0];
        y = p[509:255] + s[255:1];
        z = ~p[764:510];
        t = p[1019:765] + 255'd1;
        return {t, z, y, x};
    endfunction

    // Engine stub: latches operands on start, checks they stay put, pulses done after eng_lat cycles.
    logic          eng_busy = 1'b0;
    int            eng_cnt  = 0;
    int            eng_lat  = 6;
    bit            chk_en   = 1'b1;
    logic [1275:0] snap     = '0;
    int            stab_bad = 0;
    int            start_bad = 0;
    assign mul_busy = eng_busy;

    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (eng_busy) begin
            if (chk_en && {mul_scalar, mul_base_t, mul_base_z, mul_base_y, mul_base_x} !== snap)
                stab_bad <= stab_bad + 1;
            if (mul_start) start_bad <= start_bad + 1;
            if (eng_cnt <= 1) begin
                eng_busy <= 1'b0;
                mul_done <= 1'b1;
                {mul_res_t, mul_res_z, mul_res_y, mul_res_x} <= eng_f(snap[1275:1020], snap[1019:0]);
            end
            eng_cnt <= eng_cnt - 1;
        end else if (mul_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_lat;
            snap     <= {mul_scalar, mul_base_t, mul_base_z, mul_base_y, mul_base_x};
        end
    end

    int            vec = 0;
    int            bad = 0;
    int            cyc_n = 0;
    int            starts = 0;
    int            t_start = 0;
    int            resp_n = 0;
    int            excl_bad = 0;
    int            t_acc  [2];
    int            t_take [2];
    int            t_rsv  [2];
    int            rs_cnt [2];
    int            resubmit [2];
    bit            acc_pend [2];
    bit            take_pend [2];
    bit            auto_rs [2];
    bit            exp_err = 1'b0;
    logic [255:0]  acc_s [2];
    logic [1019:0] acc_p [2];
    int            grants [$];
    int            ghist  [$];

    function automatic logic [127:0] fold(input logic [1023:0] v);
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f ^= v[i*128 +: 128];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, fold(obs), fold(exp));
        end
    endtask

    function automatic logic [255:0] r256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [1019:0] r1020();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r[1019:0];
    endfunction

    task automatic submit(input int p, input logic [255:0] s, input logic [1019:0] pt);
        rq_scalar[p] = s;
        rq_point[p]  = pt;
        rq_valid[p]  = 1'b1;
    endtask

    task automatic check_resp(input int p);
        int g;
        logic [1019:0] exp_pt;
        g = (grants.size() == 0) ? -1 : grants.pop_front();
        chk("resp_port", 1024'(p), 1024'(g));
        exp_pt = exp_err ? 1020'd0 : eng_f(acc_s[p], acc_p[p]);
        chk("resp_point", {4'd0, rs_point[p]}, {4'd0, exp_pt});
        chk("resp_err", 1024'(rs_err[p]), 1024'(exp_err));
        rs_ready[p]  = 1'b1;
        take_pend[p] = 1'b1;
        t_take[p]    = cyc_n;
        t_rsv[p]     = cyc_n;
        resp_n++;
    endtask

    // One clock: retire handshakes just after the edge, observe everything at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (acc_pend[p]) begin
                rq_valid[p] = 1'b0;
                acc_pend[p] = 1'b0;
                if (resubmit[p] > 0) begin
                    resubmit[p]--;
                    submit(p, r256(), r1020());
                end
            end
            if (take_pend[p]) begin
                rs_ready[p]  = 1'b0;
                take_pend[p] = 1'b0;
            end
        end
        @(negedge clk);
        cyc_n++;
        if (mul_start) begin
            starts++;
            t_start = cyc_n;
        end
        if (rq_ready[0] && rq_ready[1]) excl_bad++;
        if (rs_valid[0] && rs_valid[1]) excl_bad++;
        for (int p = 0; p < 2; p++) begin
            if (rq_valid[p] && rq_ready[p] && !acc_pend[p]) begin
                acc_pend[p] = 1'b1;
                acc_s[p]    = rq_scalar[p];
                acc_p[p]    = rq_point[p];
                t_acc[p]    = cyc_n;
                grants.push_back(p);
                ghist.push_back(p);
            end
            if (rs_valid[p]) rs_cnt[p]++;
            if (rs_valid[p] && auto_rs[p] && !take_pend[p]) check_resp(p);
        end
    endtask

    task automatic wait_resp(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (resp_n < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 1024'(resp_n), 1024'(n));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        grants.delete();
        for (int p = 0; p < 2; p++) begin
            acc_pend[p] = 1'b0;
            rq_valid[p] = 1'b0;
        end
        rst = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int s0, c0, c1, k, hold_bad, n;
        logic [1019:0] hp;

        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rq_valid[p] = 1'b0; rq_scalar[p] = '0; rq_point[p] = '0; rs_ready[p] = 1'b0;
            t_acc[p] = 0; t_take[p] = 0; t_rsv[p] = 0; rs_cnt[p] = 0; resubmit[p] = 0;
            acc_pend[p] = 1'b0; take_pend[p] = 1'b0; auto_rs[p] = 1'b1;
        end
        tick();
        tick();
        chk("rst_rq0_ready", 1024'(rq_ready[0]), 1024'(0));
        chk("rst_rq1_ready", 1024'(rq_ready[1]), 1024'(0));
        chk("rst_rs_valid", 1024'({rs_valid[1], rs_valid[0]}), 1024'(0));
        chk("rst_rs_err", 1024'({rs_err[1], rs_err[0]}), 1024'(0));
        chk("rst_mul_start", 1024'(mul_start), 1024'(0));
        chk("rst_timeout_cnt", 1024'(timeout_cnt), 1024'(0));
        chk("rst_operands", {mul_scalar, mul_base_t, mul_base_z, mul_base_y, mul_base_x}, 1024'(0));
        chk("rst_rs0_point", {4'd0, rs_point[0]}, 1024'(0));
        rst = 1'b1;
        tick();

        // Single job on port 0 with scalar 1.
        s0 = starts;
        c1 = rs_cnt[1];
        submit(0, 256'd1, r1020());
        wait_resp(1, 200, "t1_done");
        chk("t1_start_count", 1024'(starts - s0), 1024'(1));
        chk("t1_engine_scalar", 1024'(snap[1275:1020]), 1024'(1));
        chk("t1_rs1_quiet", 1024'(rs_cnt[1]), 1024'(c1));

        // Simultaneous requests straight after reset: port 0 first, then port 1.
        do_reset();
        n = ghist.size();
        submit(0, 256'd5, r1020());
        submit(1, 256'd7, r1020());
        wait_resp(resp_n + 2, 300, "t2_done");
        chk("t2_first_grant", 1024'(ghist[n]), 1024'(0));
        chk("t2_second_grant", 1024'(ghist[n + 1]), 1024'(1));
        chk("t2_p1_accept_after_p0_take", 1024'(t_acc[1] - t_take[0]), 1024'(2));

        // Continuous requests on both ports: four jobs alternate 0,1,0,1.
        n = ghist.size();
        resubmit[0] = 1;
        resubmit[1] = 1;
        submit(0, r256(), r1020());
        submit(1, r256(), r1020());
        wait_resp(resp_n + 4, 600, "t3_done");
        for (int i = 0; i < 4; i++) chk("t3_grant_order", 1024'(ghist[n + i]), 1024'(i % 2));

        // Engine that finishes far too late: watchdog abort after 100 cycles.
        eng_lat = 300;
        exp_err = 1'b1;
        submit(0, r256(), r1020());
        wait_resp(resp_n + 1, 300, "t4_abort");
        chk("t4_abort_latency", 1024'(t_rsv[0] - t_start), 1024'(101));
        chk("t4_timeout_cnt", 1024'(timeout_cnt), 1024'(1));
        exp_err = 1'b0;
        eng_lat = 6;
        submit(1, r256(), r1020());
        wait_resp(resp_n + 1, 600, "t4_next_job");
        chk("t4_timeout_cnt_after", 1024'(timeout_cnt), 1024'(1));

        // Stalled port 1 response blocks a pending port 0 request.
        eng_lat = 8;
        auto_rs[1] = 1'b0;
        n = ghist.size();
        submit(1, r256(), r1020());
        k = 0;
        while (ghist.size() == n && k < 50) begin tick(); k++; end
        chk("t5_p1_accepted", 1024'(ghist.size()), 1024'(n + 1));
        submit(0, r256(), r1020());
        k = 0;
        while (!rs_valid[1] && k < 100) begin tick(); k++; end
        chk("t5_rs1_valid", 1024'(rs_valid[1]), 1024'(1));
        hp = rs_point[1];
        s0 = starts;
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!rs_valid[1] || rs_point[1] !== hp || rq_ready[0]) hold_bad++;
        end
        chk("t5_hold_stable", 1024'(hold_bad), 1024'(0));
        chk("t5_no_start", 1024'(starts - s0), 1024'(0));
        auto_rs[1] = 1'b1;
        wait_resp(resp_n + 2, 200, "t5_done");
        chk("t5_p0_accept_latency", 1024'(t_acc[0] - t_take[1]), 1024'(2));

        // Reset in the middle of WAIT; the engine's late done must be ignored.
        eng_lat = 18;
        s0 = starts;
        submit(0, r256(), r1020());
        k = 0;
        while (starts == s0 && k < 50) begin tick(); k++; end
        for (int i = 0; i < 5; i++) tick();
        chk_en = 1'b0;
        rst = 1'b0;
        grants.delete();
        acc_pend[0] = 1'b0;
        tick();
        chk("t6_rst_ready", 1024'({rq_ready[1], rq_ready[0]}), 1024'(0));
        chk("t6_rst_valid", 1024'({rs_valid[1], rs_valid[0]}), 1024'(0));
        chk("t6_rst_start", 1024'(mul_start), 1024'(0));
        chk("t6_rst_operands", {mul_scalar, mul_base_t, mul_base_z, mul_base_y, mul_base_x}, 1024'(0));
        chk("t6_rst_point", {4'd0, rs_point[0]}, 1024'(0));
        chk("t6_rst_timeout_cnt", 1024'(timeout_cnt), 1024'(0));
        tick();
        rst = 1'b1;
        c0 = rs_cnt[0];
        c1 = rs_cnt[1];
        s0 = starts;
        for (int i = 0; i < 25; i++) tick();
        chk("t6_no_response", 1024'(rs_cnt[0] + rs_cnt[1]), 1024'(c0 + c1));
        chk("t6_no_start", 1024'(starts - s0), 1024'(0));
        chk_en = 1'b1;
        eng_lat = 6;
        submit(1, r256(), r1020());
        wait_resp(resp_n + 1, 200, "t6_fresh_job");

        chk("exclusive_handshakes", 1024'(excl_bad), 1024'(0));
        chk("operands_stable", 1024'(stab_bad), 1024'(0));
        chk("no_start_while_busy", 1024'(start_bad), 1024'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
